isa_io_frontend: RTL
====================

# isa_io_frontend

ISA I/O slave front-end sitting directly upstream of the `sound` block. Synchronises the raw ISA strobes into `clk`, latches the address on BALE, decodes the SB/FM/joystick/MPU windows, and issues single-cycle `io_write`/`io_read` strobes with byte-lane-corrected data. On reads it captures the sound block's response and drives the ISA data bus and the transceiver direction pins for the rest of the IOR cycle.

## Interface
Parameters:
- `SB_BASE`, 16'h0220: SB window base; 16 ports.
- `FM_BASE`, 16'h0388: FM window base; 4 ports.
- `JOY_ADDR`, 16'h0201: joystick port; 1 port.
- `MPU_BASE`, 16'h0330: MPU window base; 2 ports.
- `TIMEOUT_CYCLES`, 255: maximum `clk` cycles a strobe may stay active before the cycle is aborted. 8-bit counter.

Ports:
- `clk`  in  1: system clock (ISA CLK domain).
- `reset`  in  1: asynchronous, active-high.
- `isa_ior_n`, `isa_iow_n`, `isa_bale`, `isa_aen`, `isa_sbhe_n`  in  1 each: raw ISA control.
- `isa_sa`  in  16: raw ISA address.
- `isa_sd_in`  in  16: ISA data from the transceivers.
- `isa_sd_out`  out  16: read data to the bus.
- `isa_sd_oe`  out  1: tri-state enable for `isa_sd_out`.
- `sd70_dir`, `sd158_dir`  out  1 each: transceiver direction; 0 = FPGA drives the bus.
- `io_address`  out  4: latched address [3:0].
- `io_writedata`  out  8: byte-lane-selected write data.
- `io_write`, `io_read`  out  1 each: single-cycle strobes.
- `io_readdata`  in  8: sound block read data.
- `sb_cs`, `fm_cs`, `joy_cs`, `mpu_cs`  out  1 each: registered window decodes.
- `cycle_abort`  out  1: one-cycle pulse on watchdog or illegal cycle.

## Operation
- Sync: 2-flop synchroniser on IOR_N, IOW_N, BALE and AEN. SA, SD and SBHE_N are sampled through one register stage.
- Address: on the synchronised BALE falling edge, latch SA[15:0]. The chip selects are decoded from the latch, gated with synchronised AEN low, and registered.
- FSM states:
  - WAIT_IDLE: entered from reset. Moves to IDLE only once both synced strobes have been high for one cycle.
  - IDLE: on IOW falling with any CS → WRITE. On IOR falling with any CS → READ_CAP. A strobe with no CS or with AEN high is ignored and the FSM stays in IDLE.
  - WRITE: every cycle, capture `isa_sd_in` and SBHE_N. On IOW rising → pulse `io_write` with the last captured data → IDLE.
  - READ_CAP: `io_read` is pulsed on entry. One cycle later, `io_readdata` is latched into {rd,rd} on `isa_sd_out` → READ_DRIVE.
  - READ_DRIVE: `isa_sd_oe` = 1 and `sd70_dir` = `sd158_dir` = 0. On IOR rising → release the bus → IDLE.
- Byte lane rule: `io_writedata` = (SBHE_N low and addr[0] = 1) ? sd[15:8] : sd[7:0].
- Watchdog: the counter clears on entry to WRITE, READ_CAP or READ_DRIVE and increments every cycle in those states. When the count reaches TIMEOUT_CYCLES: pulse `cycle_abort`, suppress `io_write`, release the bus, → WAIT_IDLE.
- Both synced strobes low together in any state: pulse `cycle_abort` → WAIT_IDLE.
- A BALE falling edge while not in IDLE still updates the address latch. The CS outputs are frozen until the FSM returns to IDLE.

## Timing
- Reset values:
  - All strobes, all CS outputs, `isa_sd_oe`, `cycle_abort`: 0.
  - `isa_sd_out`, `io_address`, `io_writedata`: 0.
  - `sd70_dir`, `sd158_dir`: 1.
  - FSM: WAIT_IDLE. Counter: 0.
- Raw edge to FSM action: 3 `clk` cycles (2 sync + 1 edge detect). Add 2 cycles with the filter enabled.
- `io_write` asserts 1 cycle after the synced IOW rising edge. `io_writedata` and `io_address` are stable in that cycle and are held until the next cycle.
- `io_readdata` is sampled exactly 1 cycle after `io_read`. `isa_sd_oe` asserts the following cycle.
- `isa_sd_oe` and the dir pins release in the same cycle the synced IOR rising edge is seen.
- Reset mid-cycle: the bus is released immediately (asynchronous). The in-progress cycle is discarded via WAIT_IDLE.

## Configuration
- `ISA_STROBE_FILTER_EN`
  - Defined: IOR_N, IOW_N and BALE pass through an additional 3-sample majority filter after the synchroniser, adding 2 cycles of latency. Glitches of 1 cycle are rejected.
  - Undefined: no filter; latency as in Timing.

## Structure
- `isa_io_pkg` holds:
  - default base-address constants;
  - window sizes;
  - FSM state enum (WAIT_IDLE, IDLE, WRITE, READ_CAP, READ_DRIVE);
  - watchdog counter width.
- Sub-module `isa_sync_edge` is instantiated once per control signal. It contains the synchroniser, the optional majority filter, and outputs `level`, `rise` and `fall`.

## Test plan
- Write 0x388 with SD = 0x00A5 and SBHE_N high → one `io_write` pulse, `fm_cs` = 1, `io_address` = 8, `io_writedata` = 0xA5.
- Write 0x389 with SD = 0x5A00 and SBHE_N low → `io_writedata` = 0x5A, `io_address` = 9.
- Read 0x22A with `io_readdata` = 0xAA → one `io_read` pulse, `isa_sd_out` = 0xAAAA, OE and dir active until IOR rises, then released.
- IOW low to 0x220 with AEN high, then to 0x300 with AEN low → no strobes and no CS in either case.
- IOR held low for 300 cycles → `cycle_abort` at count 255, bus released, no further strobes until both strobes go high.
- Reset asserted during READ_DRIVE → `isa_sd_oe` = 0 immediately. After release, with IOR still low, no `io_read` occurs until IOR rises.
- With `ISA_STROBE_FILTER_EN`, a 1-cycle IOW low glitch produces no `io_write`.

Source files
------------

// File: rtl/isa_io_pkg.sv
// Shared constants, FSM state type and window-decode helper for the ISA I/O front-end.
// Build option: define ISA_STROBE_FILTER_EN to add the 3-sample strobe majority filter.
package isa_io_pkg;

   localparam logic [15:0] SB_BASE_DEF  = 16'h0220;
   localparam logic [15:0] FM_BASE_DEF  = 16'h0388;
   localparam logic [15:0] JOY_ADDR_DEF = 16'h0201;
   localparam logic [15:0] MPU_BASE_DEF = 16'h0330;

   localparam int unsigned SB_SIZE  = 16;
   localparam int unsigned FM_SIZE  = 4;
   localparam int unsigned JOY_SIZE = 1;
   localparam int unsigned MPU_SIZE = 2;

   localparam int unsigned WDOG_W = 8;

`ifdef ISA_STROBE_FILTER_EN
   localparam bit STROBE_FILTER = 1'b1;
`else
   localparam bit STROBE_FILTER = 1'b0;
`endif

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      WRITE,
      READ_CAP,
      READ_DRIVE
   } state_e;

   // Unsigned wrap makes addresses below the base fall outside the window too.
   function automatic logic in_window(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input int unsigned size);
      logic [15:0] off;
      off = addr - base;
      return off < 16'(size);
   endfunction

endpackage

// File: rtl/isa_sync_edge.sv
// Two-flop synchroniser with optional majority filter (ISA_STROBE_FILTER_EN) and edge detect.
// FILTER selects whether this instance may use the filter when the build enables it.
module isa_sync_edge
   import isa_io_pkg::*;
#(
   parameter logic RST_VAL = 1'b0,
   parameter bit   FILTER  = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q, s2_q, prev_q, lvl;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   generate
      if (FILTER && STROBE_FILTER) begin : g_filt
         logic h1_q, h2_q, maj_q;
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               h1_q  <= RST_VAL;
               h2_q  <= RST_VAL;
               maj_q <= RST_VAL;
            end else begin
               h1_q  <= s2_q;
               h2_q  <= h1_q;
               maj_q <= (s2_q & h1_q) | (s2_q & h2_q) | (h1_q & h2_q);
            end
         end
         assign lvl = maj_q;
      end else begin : g_nofilt
         assign lvl = s2_q;
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) prev_q <= RST_VAL;
      else       prev_q <= lvl;
   end

   assign level_o = lvl;
   assign rise_o  = lvl & ~prev_q;
   assign fall_o  = ~lvl & prev_q;

endmodule

// File: rtl/isa_io_frontend.sv
// ISA I/O slave front-end: strobe sync, address latch/decode, write/read strobes, bus drive.
// Build option: ISA_STROBE_FILTER_EN adds 2 cycles of strobe latency and rejects 1-cycle glitches.
module isa_io_frontend
   import isa_io_pkg::*;
#(
   parameter logic [15:0] SB_BASE        = SB_BASE_DEF,
   parameter logic [15:0] FM_BASE        = FM_BASE_DEF,
   parameter logic [15:0] JOY_ADDR       = JOY_ADDR_DEF,
   parameter logic [15:0] MPU_BASE       = MPU_BASE_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        isa_ior_n,
   input  logic        isa_iow_n,
   input  logic        isa_bale,
   input  logic        isa_aen,
   input  logic        isa_sbhe_n,
   input  logic [15:0] isa_sa,
   input  logic [15:0] isa_sd_in,
   output logic [15:0] isa_sd_out,
   output logic        isa_sd_oe,
   output logic        sd70_dir,
   output logic        sd158_dir,
   output logic [3:0]  io_address,
   output logic [7:0]  io_writedata,
   output logic        io_write,
   output logic        io_read,
   input  logic [7:0]  io_readdata,
   output logic        sb_cs,
   output logic        fm_cs,
   output logic        joy_cs,
   output logic        mpu_cs,
   output logic        cycle_abort
);

   localparam logic [WDOG_W-1:0] TMO = WDOG_W'(TIMEOUT_CYCLES);

   logic ior_lvl, ior_rise, ior_fall;
   logic iow_lvl, iow_rise, iow_fall;
   logic bale_lvl, bale_rise, bale_fall;
   logic aen_lvl, aen_rise, aen_fall;

   // Strobes reset to "asserted" so a reset never fabricates an idle bus or a false falling edge.
   isa_sync_edge #(.RST_VAL(1'b0), .FILTER(1'b1)) u_ior (
      .clk_i(clk), .rst_i(reset), .d_i(isa_ior_n),
      .level_o(ior_lvl), .rise_o(ior_rise), .fall_o(ior_fall));
   isa_sync_edge #(.RST_VAL(1'b0), .FILTER(1'b1)) u_iow (
      .clk_i(clk), .rst_i(reset), .d_i(isa_iow_n),
      .level_o(iow_lvl), .rise_o(iow_rise), .fall_o(iow_fall));
   isa_sync_edge #(.RST_VAL(1'b0), .FILTER(1'b1)) u_bale (
      .clk_i(clk), .rst_i(reset), .d_i(isa_bale),
      .level_o(bale_lvl), .rise_o(bale_rise), .fall_o(bale_fall));
   isa_sync_edge #(.RST_VAL(1'b1), .FILTER(1'b0)) u_aen (
      .clk_i(clk), .rst_i(reset), .d_i(isa_aen),
      .level_o(aen_lvl), .rise_o(aen_rise), .fall_o(aen_fall));

   logic unused_sync;
   assign unused_sync = ^{bale_lvl, bale_rise, aen_rise, aen_fall};

   logic [15:0] sa_q, sd_q, addr_q;
   logic        sbhe_n_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sa_q     <= '0;
         sd_q     <= '0;
         sbhe_n_q <= 1'b1;
         addr_q   <= '0;
      end else begin
         sa_q     <= isa_sa;
         sd_q     <= isa_sd_in;
         sbhe_n_q <= isa_sbhe_n;
         if (bale_fall) addr_q <= sa_q;
      end
   end

   state_e state_q, state_d;
   logic [3:0] cs_q, cs_hit;
   logic       cs_any;

   assign cs_hit = {in_window(addr_q, SB_BASE, SB_SIZE),
                    in_window(addr_q, FM_BASE, FM_SIZE),
                    in_window(addr_q, JOY_ADDR, JOY_SIZE),
                    in_window(addr_q, MPU_BASE, MPU_SIZE)} & {4{~aen_lvl}};
   assign cs_any = |cs_q;

   // CS only tracks the latch while idle, so a BALE mid-cycle cannot retarget the cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                cs_q <= '0;
      else if (state_q == IDLE) cs_q <= cs_hit;
   end

   assign {sb_cs, fm_cs, joy_cs, mpu_cs} = cs_q;

   logic [WDOG_W-1:0] cnt_q, cnt_d;
   logic [15:0] cap_data_q, cap_data_d, sd_out_q, sd_out_d;
   logic        cap_sbhe_q, cap_sbhe_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [3:0]  addr_out_q, addr_out_d;
   logic        write_q, write_d, read_q, read_d, abort_q, abort_d;
   logic        active;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cap_data_d = cap_data_q;
      cap_sbhe_d = cap_sbhe_q;
      sd_out_d   = sd_out_q;
      wdata_d    = wdata_q;
      addr_out_d = addr_out_q;
      write_d    = 1'b0;
      read_d     = 1'b0;
      abort_d    = 1'b0;
      active     = (state_q inside {WRITE, READ_CAP, READ_DRIVE});

      if (active) cnt_d = cnt_q + WDOG_W'(1);

      if (!ior_lvl && !iow_lvl && state_q != WAIT_IDLE) begin
         abort_d = 1'b1;
         state_d = WAIT_IDLE;
      end else if (active && cnt_q == TMO) begin
         abort_d = 1'b1;
         state_d = WAIT_IDLE;
      end else begin
         unique case (state_q)
            WAIT_IDLE: begin
               if (ior_lvl && iow_lvl) state_d = IDLE;
            end
            IDLE: begin
               if (cs_any && !aen_lvl) begin
                  if (iow_fall) begin
                     state_d = WRITE;
                     cnt_d   = '0;
                  end else if (ior_fall) begin
                     state_d    = READ_CAP;
                     cnt_d      = '0;
                     read_d     = 1'b1;
                     addr_out_d = addr_q[3:0];
                  end
               end
            end
            WRITE: begin
               cap_data_d = sd_q;
               cap_sbhe_d = sbhe_n_q;
               if (iow_rise) begin
                  write_d    = 1'b1;
                  addr_out_d = addr_q[3:0];
                  wdata_d    = (!cap_sbhe_q && addr_q[0]) ? cap_data_q[15:8] : cap_data_q[7:0];
                  state_d    = IDLE;
               end
            end
            READ_CAP: begin
               if (cnt_q == WDOG_W'(1)) begin
                  sd_out_d = {io_readdata, io_readdata};
                  cnt_d    = '0;
                  state_d  = READ_DRIVE;
               end
            end
            READ_DRIVE: begin
               if (ior_rise) state_d = IDLE;
            end
            default: state_d = WAIT_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= WAIT_IDLE;
         cnt_q      <= '0;
         cap_data_q <= '0;
         cap_sbhe_q <= 1'b1;
         sd_out_q   <= '0;
         wdata_q    <= '0;
         addr_out_q <= '0;
         write_q    <= 1'b0;
         read_q     <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cap_data_q <= cap_data_d;
         cap_sbhe_q <= cap_sbhe_d;
         sd_out_q   <= sd_out_d;
         wdata_q    <= wdata_d;
         addr_out_q <= addr_out_d;
         write_q    <= write_d;
         read_q     <= read_d;
         abort_q    <= abort_d;
      end
   end

   // Drive is released combinationally in the cycle the synced IOR rise is seen.
   assign isa_sd_oe    = (state_q == READ_DRIVE) && !ior_rise;
   assign sd70_dir     = ~isa_sd_oe;
   assign sd158_dir    = ~isa_sd_oe;
   assign isa_sd_out   = sd_out_q;
   assign io_address   = addr_out_q;
   assign io_writedata = wdata_q;
   assign io_write     = write_q;
   assign io_read      = read_q;
   assign cycle_abort  = abort_q;

endmodule
